// File: rtl/s2p_cond_if.sv
// -----------------------------------------------------------------------------
// s2p_cond_if
// Groups the lane/strobe inputs and byte/status outputs of the 4-lane
// serial-to-parallel receiver (s2p_cond). Clock and reset stay plain ports
// on the receiver itself.
//
// Signals
//   IN_ENB_s2p     bit strobe; lanes are sampled only on edges where high
//   IN_LANE_s2p    one serial bit per lane, lane 0 carries the sync byte
//   IN_RESYNC_s2p  forces loss of lock and a return to the hunting state
//   OUT_LANE3_s2p  deserialized byte for lane 3 (LANE2/1/0 likewise)
//   OUT_VALID_s2p  one-cycle strobe: the four byte outputs carry a new set
//   OUT_LOCK_s2p   high while the receiver is locked to the byte framing
//
// Modports
//   master  drives the serial side and observes the parallel side (bench/link)
//   slave   the receiver itself
// -----------------------------------------------------------------------------
interface s2p_cond_if;
  logic       IN_ENB_s2p;
  logic [3:0] IN_LANE_s2p;
  logic       IN_RESYNC_s2p;
  logic [7:0] OUT_LANE3_s2p;
  logic [7:0] OUT_LANE2_s2p;
  logic [7:0] OUT_LANE1_s2p;
  logic [7:0] OUT_LANE0_s2p;
  logic       OUT_VALID_s2p;
  logic       OUT_LOCK_s2p;

  modport master (
    output IN_ENB_s2p,
    output IN_LANE_s2p,
    output IN_RESYNC_s2p,
    input  OUT_LANE3_s2p,
    input  OUT_LANE2_s2p,
    input  OUT_LANE1_s2p,
    input  OUT_LANE0_s2p,
    input  OUT_VALID_s2p,
    input  OUT_LOCK_s2p
  );

  modport slave (
    input  IN_ENB_s2p,
    input  IN_LANE_s2p,
    input  IN_RESYNC_s2p,
    output OUT_LANE3_s2p,
    output OUT_LANE2_s2p,
    output OUT_LANE1_s2p,
    output OUT_LANE0_s2p,
    output OUT_VALID_s2p,
    output OUT_LOCK_s2p
  );
endinterface

// File: rtl/s2p_cond.sv
// -----------------------------------------------------------------------------
// s2p_cond
// 4-lane serial-to-parallel receiver, the receive-side counterpart of the
// 4-lane p2s transmitter. Each enabled clock shifts one bit per lane into an
// 8-bit register, LSB first. Byte framing is recovered by hunting SYNC_WORD on
// lane 0; after SYNC_COUNT consecutive aligned sync bytes the receiver locks
// and then presents four bytes with a one-cycle valid strobe every 8 enabled
// bits.
//
// Parameters
//   SYNC_WORD   alignment byte, received LSB first on lane 0 (default 8'hBC)
//   SYNC_COUNT  consecutive aligned sync bytes needed for lock, 1..7
//
// Ports
//   IN_CLK_s2p    in  clock, rising edge
//   IN_RST_N_s2p  in  asynchronous reset, active low
//   bus           s2p_cond_if.slave: lane bits, enable, resync in;
//                 four lane bytes, valid strobe, lock flag out
//
// Configuration macro
//   S2P_SYNC_DROP_EN  when defined, a locked byte set whose lane-0 byte equals
//                     SYNC_WORD is swallowed: no strobe, outputs hold.
//                     When undefined every locked byte set is strobed.
// -----------------------------------------------------------------------------
module s2p_cond #(
  parameter logic [7:0]  SYNC_WORD  = 8'hBC,
  parameter int unsigned SYNC_COUNT = 2
) (
  input  logic       IN_CLK_s2p,
  input  logic       IN_RST_N_s2p,
  s2p_cond_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [2:0] SYNC_CNT_L = 3'(SYNC_COUNT);
  localparam logic [3:0] FILL_FULL  = 4'd8;

  state_e           state_q, state_d;
  logic [3:0][7:0]  sr_q, sr_d;        // per-lane shift registers, sr_q[0] is the sync window
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       fill_q, fill_d;    // bits seen since the hunt (re)started, saturates at 8
  logic [2:0]       match_q, match_d;  // aligned sync bytes seen so far
  logic [3:0][7:0]  out_q, out_d;
  logic             valid_q, valid_d;
  logic             lock_q, lock_d;

  logic [3:0][7:0]  sr_shift_s;        // shift-register contents after taking the current bits
  logic [3:0]       fill_inc_s;
  logic [2:0]       match_inc_s;
  logic             sync_hit_s;        // lane-0 window including the current bit is SYNC_WORD
  logic             byte_end_s;        // this edge samples bit 7 of a framed byte

  // Next shift value per lane: new bit enters at the MSB so the first bit lands at bit 0.
  always_comb begin
    sr_shift_s = sr_q;
    for (int i = 0; i < 4; i++) begin
      sr_shift_s[i] = {bus.IN_LANE_s2p[i], sr_q[i][7:1]};
    end
  end

  assign sync_hit_s  = (sr_shift_s[0] == SYNC_WORD);
  assign fill_inc_s  = (fill_q == FILL_FULL) ? FILL_FULL : (fill_q + 4'd1);
  assign match_inc_s = match_q + 3'd1;
  assign byte_end_s  = (bit_cnt_q == 3'd7);

  // Next-state, counter, shift and output-register logic.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    fill_d    = fill_q;
    match_d   = match_q;
    out_d     = out_q;
    valid_d   = 1'b0;

    if (bus.IN_RESYNC_s2p) begin
      // Resync beats a simultaneous enable: the sampled bit is thrown away
      // and the hunt restarts from an empty window. Byte outputs hold.
      state_d   = ST_SEARCH;
      sr_d      = '0;
      bit_cnt_d = 3'd0;
      fill_d    = 4'd0;
      match_d   = 3'd0;
    end else if (bus.IN_ENB_s2p) begin
      sr_d = sr_shift_s;
      case (state_q)
        ST_SEARCH: begin
          bit_cnt_d = 3'd0;
          fill_d    = fill_inc_s;
          // A match is only trusted once the window holds 8 real bits.
          if ((fill_inc_s == FILL_FULL) && sync_hit_s) begin
            match_d = 3'd1;
            if (SYNC_CNT_L == 3'd1) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_VERIFY;
            end
          end else begin
            state_d = ST_SEARCH;
          end
        end

        ST_VERIFY: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_end_s) begin
            if (sync_hit_s) begin
              match_d = match_inc_s;
              if (match_inc_s == SYNC_CNT_L) begin
                state_d = ST_LOCKED;
              end else begin
                state_d = ST_VERIFY;
              end
            end else begin
              // Framing not confirmed: hunt again with a fresh 8-bit fill.
              state_d   = ST_SEARCH;
              bit_cnt_d = 3'd0;
              fill_d    = 4'd0;
              match_d   = 3'd0;
            end
          end else begin
            state_d = ST_VERIFY;
          end
        end

        ST_LOCKED: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_end_s) begin
`ifdef S2P_SYNC_DROP_EN
            // Sync bytes embedded in the data stream are swallowed.
            if (sync_hit_s) begin
              out_d   = out_q;
              valid_d = 1'b0;
            end else begin
              out_d   = sr_shift_s;
              valid_d = 1'b1;
            end
`else
            out_d   = sr_shift_s;
            valid_d = 1'b1;
`endif
          end else begin
            valid_d = 1'b0;
          end
        end

        default: begin
          state_d   = ST_SEARCH;
          bit_cnt_d = 3'd0;
          fill_d    = 4'd0;
          match_d   = 3'd0;
        end
      endcase
    end else begin
      // No bit strobe: everything holds, no valid.
      state_d = state_q;
    end
  end

  // Lock flag follows the state being entered, so it rises with the LOCKED state register.
  assign lock_d = (state_d == ST_LOCKED);

  // State, datapath and output registers.
  always_ff @(posedge IN_CLK_s2p or negedge IN_RST_N_s2p) begin
    if (!IN_RST_N_s2p) begin
      state_q   <= ST_SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= 3'd0;
      fill_q    <= 4'd0;
      match_q   <= 3'd0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      lock_q    <= lock_d;
    end
  end

  assign bus.OUT_LANE3_s2p = out_q[3];
  assign bus.OUT_LANE2_s2p = out_q[2];
  assign bus.OUT_LANE1_s2p = out_q[1];
  assign bus.OUT_LANE0_s2p = out_q[0];
  assign bus.OUT_VALID_s2p = valid_q;
  assign bus.OUT_LOCK_s2p  = lock_q;

endmodule

// File: tb/tb_s2p_cond.sv
// -----------------------------------------------------------------------------
// tb_s2p_cond
// Directed bench for s2p_cond with SYNC_WORD = 8'hBC, SYNC_COUNT = 2.
// A table of byte sets drives the lock-up and data flow; hand-written
// sequences cover idle hunting, enable gaps, resync, a failed verify and
// an asynchronous reset in the middle of a byte.
// -----------------------------------------------------------------------------
module tb_s2p_cond;

  logic clk = 1'b0;
  logic rst_n;

  // 100 MHz style clock.
  always #5 clk = ~clk;

  s2p_cond_if bus ();

  s2p_cond #(.SYNC_WORD(8'hBC), .SYNC_COUNT(2)) dut (
    .IN_CLK_s2p   (clk),
    .IN_RST_N_s2p (rst_n),
    .bus          (bus)
  );

  typedef struct {
    logic [7:0] l3, l2, l1, l0;   // byte sent on each lane
    int         nvalid;           // strobes expected while sending it
    logic [7:0] e3, e2, e1, e0;   // outputs expected afterwards
    logic       lock;             // lock flag expected afterwards
  } vec_t;

  vec_t vecs [6];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [7:0] e3, input logic [7:0] e2,
                            input logic [7:0] e1, input logic [7:0] e0);
    check({name, ".out3"}, {24'd0, bus.OUT_LANE3_s2p}, {24'd0, e3});
    check({name, ".out2"}, {24'd0, bus.OUT_LANE2_s2p}, {24'd0, e2});
    check({name, ".out1"}, {24'd0, bus.OUT_LANE1_s2p}, {24'd0, e1});
    check({name, ".out0"}, {24'd0, bus.OUT_LANE0_s2p}, {24'd0, e0});
  endtask

  // Send one byte per lane, LSB first; with gap set, each enabled edge is
  // followed by one disabled edge carrying junk lane values.
  task automatic send_set(input logic [7:0] l3, input logic [7:0] l2, input logic [7:0] l1,
                          input logic [7:0] l0, input bit gap, output int nvalid);
    nvalid = 0;
    for (int b = 0; b < 8; b++) begin
      bus.IN_LANE_s2p = {l3[b], l2[b], l1[b], l0[b]};
      bus.IN_ENB_s2p  = 1'b1;
      @(posedge clk); #1;
      if (bus.OUT_VALID_s2p === 1'b1) nvalid++;
      if (gap) begin
        bus.IN_ENB_s2p  = 1'b0;
        bus.IN_LANE_s2p = ~bus.IN_LANE_s2p;
        @(posedge clk); #1;
        if (bus.OUT_VALID_s2p === 1'b1) nvalid++;
      end
    end
    bus.IN_ENB_s2p = 1'b0;
  endtask

  task automatic send_check(input string name, input logic [7:0] l3, input logic [7:0] l2,
                            input logic [7:0] l1, input logic [7:0] l0, input bit gap,
                            input int exp_nv, input logic exp_lock);
    int nv;
    send_set(l3, l2, l1, l0, gap, nv);
    check({name, ".nvalid"}, nv, exp_nv);
    check({name, ".lock"}, {31'd0, bus.OUT_LOCK_s2p}, {31'd0, exp_lock});
  endtask

  initial begin
    int nv;
    int valid_hits;
    int lock_hits;

    // Lock-up and data flow, starting from a hunting receiver full of zeros.
    vecs[0] = '{8'h00, 8'h00, 8'h00, 8'hBC, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'hBC, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h3C, 8'h0F, 8'h81, 1, 8'hA5, 8'h3C, 8'h0F, 8'h81, 1'b1};
    vecs[3] = '{8'h11, 8'h22, 8'h33, 8'h44, 1, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1};
`ifdef S2P_SYNC_DROP_EN
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 8'hBC, 0, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1};
`else
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 8'hBC, 1, 8'hFF, 8'h00, 8'hFF, 8'hBC, 1'b1};
`endif
    vecs[5] = '{8'h5A, 8'hC3, 8'h96, 8'h42, 1, 8'h5A, 8'hC3, 8'h96, 8'h42, 1'b1};

    // Reset state.
    rst_n             = 1'b0;
    bus.IN_ENB_s2p    = 1'b0;
    bus.IN_LANE_s2p   = 4'h0;
    bus.IN_RESYNC_s2p = 1'b0;
    #12;
    check("rst.valid", {31'd0, bus.OUT_VALID_s2p}, 32'd0);
    check("rst.lock",  {31'd0, bus.OUT_LOCK_s2p},  32'd0);
    check_outs("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle link: 40 enabled clocks of zeros never lock or strobe.
    valid_hits = 0;
    lock_hits  = 0;
    bus.IN_ENB_s2p  = 1'b1;
    bus.IN_LANE_s2p = 4'h0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.OUT_VALID_s2p === 1'b1) valid_hits++;
      if (bus.OUT_LOCK_s2p === 1'b1) lock_hits++;
    end
    bus.IN_ENB_s2p = 1'b0;
    check("idle.valid_hits", valid_hits, 0);
    check("idle.lock_hits", lock_hits, 0);
    check_outs("idle", 8'h00, 8'h00, 8'h00, 8'h00);

    // Table: BC, BC lock; data sets, embedded sync byte, data after it.
    for (int v = 0; v < 6; v++) begin
      send_set(vecs[v].l3, vecs[v].l2, vecs[v].l1, vecs[v].l0, 1'b0, nv);
      check($sformatf("vec%0d.nvalid", v), nv, vecs[v].nvalid);
      check($sformatf("vec%0d.lock", v), {31'd0, bus.OUT_LOCK_s2p}, {31'd0, vecs[v].lock});
      check_outs($sformatf("vec%0d", v), vecs[v].e3, vecs[v].e2, vecs[v].e1, vecs[v].e0);
    end

    // Enable toggling every clock: strobe only after 8 enabled edges, bytes intact.
    send_check("gap", 8'h69, 8'h96, 8'hE7, 8'h18, 1'b1, 1, 1'b1);
    check_outs("gap", 8'h69, 8'h96, 8'hE7, 8'h18);
    @(posedge clk); #1;
    check("gap.valid_after", {31'd0, bus.OUT_VALID_s2p}, 32'd0);

    // Resync mid-byte with enable high: lock drops next clock, no strobe, outputs hold.
    valid_hits = 0;
    bus.IN_ENB_s2p  = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bus.IN_LANE_s2p = 4'hF;
      @(posedge clk); #1;
      if (bus.OUT_VALID_s2p === 1'b1) valid_hits++;
    end
    bus.IN_RESYNC_s2p = 1'b1;
    @(posedge clk); #1;
    bus.IN_RESYNC_s2p = 1'b0;
    bus.IN_ENB_s2p    = 1'b0;
    check("resync.valid_hits", valid_hits, 0);
    check("resync.lock", {31'd0, bus.OUT_LOCK_s2p}, 32'd0);
    check("resync.valid", {31'd0, bus.OUT_VALID_s2p}, 32'd0);
    check_outs("resync", 8'h69, 8'h96, 8'hE7, 8'h18);

    // Failed verify: BC then 55 returns to hunting; BC, BC, 7E then locks.
    send_check("fail.bc", 8'h00, 8'h00, 8'h00, 8'hBC, 1'b0, 0, 1'b0);
    send_check("fail.55", 8'h00, 8'h00, 8'h00, 8'h55, 1'b0, 0, 1'b0);
    send_check("relock.bc1", 8'h00, 8'h00, 8'h00, 8'hBC, 1'b0, 0, 1'b0);
    send_check("relock.bc2", 8'h00, 8'h00, 8'h00, 8'hBC, 1'b0, 0, 1'b1);
    send_check("relock.7e", 8'h00, 8'h00, 8'h00, 8'h7E, 1'b0, 1, 1'b1);
    check_outs("relock", 8'h00, 8'h00, 8'h00, 8'h7E);

    // Asynchronous reset in the middle of a locked byte.
    bus.IN_ENB_s2p = 1'b1;
    for (int b = 0; b < 3; b++) begin
      bus.IN_LANE_s2p = 4'hA;
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.valid", {31'd0, bus.OUT_VALID_s2p}, 32'd0);
    check("midrst.lock",  {31'd0, bus.OUT_LOCK_s2p},  32'd0);
    check_outs("midrst", 8'h00, 8'h00, 8'h00, 8'h00);
    bus.IN_ENB_s2p = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // Back in hunting: ordinary data neither locks nor strobes.
    send_check("postrst", 8'h12, 8'h34, 8'h56, 8'h42, 1'b0, 0, 1'b0);
    check_outs("postrst", 8'h00, 8'h00, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
